// File: rtl/onchip_arb_pkg.sv
// rtl/onchip_arb_pkg.sv - shared constants for the on-chip memory arbiter
// Purpose: default widths, implemented depth, out-of-range read data and
//          out-of-range counter width used by onchip_memory_arbiter.
// Ports:   none (package).
package onchip_arb_pkg;
  localparam int          DEF_ADDR_W   = 14;
  localparam int          DEF_DATA_W   = 32;
  localparam int          DEF_DEPTH    = 16000;
  localparam logic [31:0] DEF_ERR_DATA = 32'h0000_0000;
  localparam int          OOR_CNT_W    = 16;
endpackage

// File: rtl/onchip_memory_arbiter_rr_arb2.sv
// rtl/onchip_memory_arbiter_rr_arb2.sv - two-way round-robin grant logic
// Purpose: grants at most one of two requesters per cycle; on a tie the
//          requester not granted last wins. Grant is combinational.
// Ports:   clk, reset_n (sync, active-low)
//          req[1:0] in  - requester active flags
//          gnt[1:0] out - one-hot grant, all zero during reset
module rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  // Index of the requester granted most recently. Resets to 1 so that
  // requester 0 wins the first tie after reset.
  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    gnt = 2'b00;
    if (reset_n) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_grant_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Only a cycle with a grant moves the round-robin pointer.
  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt[1])      last_grant_d = 1'b1;
    else if (gnt[0]) last_grant_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/onchip_memory_arbiter.sv
// rtl/onchip_memory_arbiter.sv - two-master arbiter for single-port on-chip RAM
// Purpose: shares one single-port memory (one-cycle read latency) between
//          two Avalon-MM masters, one transfer per cycle, round-robin on
//          ties. Out-of-range words are blocked, acknowledged and counted.
// Ports:   clk, reset_n (sync, active-low)
//          m0_*/m1_*   - master-side address/byteenable/read/write/writedata
//                        in; waitrequest/readdata/readdatavalid out
//          mem_*       - memory-side address/byteenable/chipselect/write/
//                        writedata/clken out; mem_readdata in
//          oor_count   - saturating count of blocked accesses
//          oor_clear   - synchronous clear of oor_count (wins over increment)
module onchip_memory_arbiter
  import onchip_arb_pkg::*;
#(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                DEPTH    = DEF_DEPTH,
  parameter logic [DATA_W-1:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic                  clk,
  input  logic                  reset_n,

  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,

  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,

  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
  input  logic [DATA_W-1:0]     mem_readdata,

  output logic [OOR_CNT_W-1:0]  oor_count,
  input  logic                  oor_clear
);

  // One extra bit so a DEPTH equal to 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

  logic [1:0] req;
  logic [1:0] gnt;

  logic       any_gnt;
  logic       sel_rd;
  logic       sel_wr;
  logic       in_range;
  logic       rd_acc;
  logic       oor_hit;

  logic [1:0]           rd_pend_q, rd_pend_d;
  logic                 rd_oor_q,  rd_oor_d;
  logic [OOR_CNT_W-1:0] oor_count_q, oor_count_d;

  assign req = {m1_read | m1_write, m0_read | m0_write};

  rr_arb2 u_rr_arb2 (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (req),
    .gnt     (gnt)
  );

  assign m0_waitrequest = ~gnt[0];
  assign m1_waitrequest = ~gnt[1];

  // Memory-side mux follows the grant; with no grant master 0 is shown but
  // chipselect stays low.
  always_comb begin
    any_gnt        = |gnt;
    mem_address    = gnt[1] ? m1_address    : m0_address;
    mem_byteenable = gnt[1] ? m1_byteenable : m0_byteenable;
    mem_writedata  = gnt[1] ? m1_writedata  : m0_writedata;
    sel_rd         = gnt[1] ? m1_read       : m0_read;
    sel_wr         = gnt[1] ? m1_write      : m0_write;
    in_range       = {1'b0, mem_address} < DEPTH_LIM;
    mem_chipselect = any_gnt & in_range;
    mem_write      = mem_chipselect & sel_wr;
    mem_clken      = reset_n;
    // Write wins when a master raises read and write together.
    rd_acc         = any_gnt & sel_rd & ~sel_wr;
    oor_hit        = any_gnt & ~in_range;
  end

  // Return tagging: which master owns next cycle's memory output, and
  // whether that return must be replaced by ERR_DATA.
  always_comb begin
    rd_pend_d = rd_acc ? gnt : 2'b00;
    rd_oor_d  = rd_acc & ~in_range;
  end

  always_comb begin
    oor_count_d = oor_count_q;
    if (oor_clear)
      oor_count_d = '0;
    else if (oor_hit && (oor_count_q != {OOR_CNT_W{1'b1}}))
      oor_count_d = oor_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_pend_q   <= 2'b00;
      rd_oor_q    <= 1'b0;
      oor_count_q <= '0;
    end else begin
      rd_pend_q   <= rd_pend_d;
      rd_oor_q    <= rd_oor_d;
      oor_count_q <= oor_count_d;
    end
  end

  // Gated by reset_n so a return pending when reset arrives never shows.
  assign m0_readdatavalid = rd_pend_q[0] & reset_n;
  assign m1_readdatavalid = rd_pend_q[1] & reset_n;
  assign m0_readdata      = rd_oor_q ? ERR_DATA : mem_readdata;
  assign m1_readdata      = rd_oor_q ? ERR_DATA : mem_readdata;
  assign oor_count        = oor_count_q;

endmodule

// File: doc/onchip_memory_arbiter.md
# onchip_memory_arbiter

Two-requester Avalon-MM arbiter that shares the single-port on-chip memory (14-bit word address, 32-bit data, byte enables, one-cycle read latency) between two masters, e.g. the Nios instruction and data paths or a Nios master and a DMA. It sits between the interconnect and the memory's s1 port. It grants one transfer per cycle with round-robin fairness and returns read data with a fixed one-cycle latency. Out-of-range words (address ≥ DEPTH) are blocked and counted.

## Interface
- ADDR_W, 14, word address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- DEPTH, 16000, number of implemented words
- ERR_DATA, 32'h0000_0000, read data returned for out-of-range reads
- clk  in  1  single clock for all logic
- reset_n  in  1  synchronous, active-low reset
- mI_address  in  ADDR_W  requester I (I = 0,1) word address
- mI_byteenable  in  DATA_W/8  requester I byte lanes
- mI_read / mI_write  in  1  requester I command
- mI_writedata  in  DATA_W  requester I write data
- mI_waitrequest  out  1  high = command not accepted this cycle
- mI_readdata  out  DATA_W  requester I read data
- mI_readdatavalid  out  1  one-cycle pulse qualifying mI_readdata
- mem_address  out  ADDR_W  to memory address
- mem_byteenable  out  DATA_W/8  to memory byteenable
- mem_chipselect / mem_write  out  1  to memory
- mem_writedata  out  DATA_W  to memory writedata
- mem_clken  out  1  memory clock enable
- mem_readdata  in  DATA_W  memory output, valid the cycle after address is presented
- oor_count  out  16  saturating count of blocked out-of-range accesses
- oor_clear  in  1  synchronous clear of oor_count

## Operation
- A requester is active when mI_read | mI_write. If both are high, write wins and the read is dropped.
- Arbitration: only one active requester → it is granted. Both active → the one not granted last is granted. `last_grant` resets to 1, so m0 wins the first tie.
- `last_grant` updates only on a cycle with a grant.
- Granted master: mI_waitrequest = 0. Every other master, and both during reset: waitrequest = 1.
- Memory side is a combinational mux of the granted master's signals. mem_chipselect = grant & in_range. mem_write = chipselect & granted write. mem_clken = reset_n.
- in_range = address < DEPTH, as an unsigned compare at ADDR_W bits.
- Out-of-range write: acknowledged (waitrequest 0), memory untouched, oor_count += 1.
- Out-of-range read: acknowledged; readdatavalid still pulses next cycle with ERR_DATA; oor_count += 1.
- oor_count saturates at 16'hFFFF. If oor_clear and an out-of-range access occur in the same cycle, the count becomes 0 (clear wins).
- Read return registers: rd_pend[1:0] (which master) and rd_oor. mI_readdata = rd_oor ? ERR_DATA : mem_readdata, driven combinationally in the return cycle.
- Back-to-back reads from both masters interleave at one transfer per cycle, and each return is tagged to its own master.

## Timing
- Grant and waitrequest are combinational from the requests and last_grant in the same cycle; the command is consumed at that cycle's clk edge.
- Read latency is exactly 1 cycle: request accepted at edge N, readdatavalid high during cycle N+1.
- Write to address A accepted at edge N; a read of A accepted at edge N+1 or later returns the new data.
- Reset values: rd_pend = 0, rd_oor = 0, last_grant = 1, oor_count = 0. All mI_readdatavalid = 0 and all mI_waitrequest = 1 while reset_n = 0.
- Reset asserted while a read return is pending: the return is discarded, and no readdatavalid pulse occurs after reset releases.
- The first grant is possible in the first cycle with reset_n = 1.

## Structure
- Package onchip_arb_pkg holds ADDR_W/DATA_W defaults, the DEPTH constant, the ERR_DATA constant and the OOR_CNT_W = 16 constant.
- Sub-module rr_arb2 contains the 2-way round-robin grant logic and the last_grant register (inputs req[1:0], outputs gnt[1:0]). The top level holds the muxing, range check, return tagging and counter.

## Test plan
- Single master: m0 reads 0x0010 every cycle for 4 cycles; m1 idle → m0_waitrequest stays 0; 4 readdatavalid pulses, each one cycle after its accept.
- Contention: both masters read continuously from reset → grants alternate m0, m1, m0, m1; each readdata matches the address that master issued.
- Write then read: m0 writes 0xA5A5_5A5A to 0x0100 with byteenable 4'b0011; m1 then reads 0x0100 → 0x????_5A5A, where the upper bytes keep their preloaded value.
- Out of range: m1 writes 16000, then reads 16383 → memory unwritten, the read returns ERR_DATA, oor_count = 2. oor_clear → 0. 65537 out-of-range accesses → 0xFFFF.
- Reset mid-read: m0 read accepted, reset_n low the next cycle → no readdatavalid; after release, m0 wins the first tie.
- Read and write both high on m0: write of 0x1234_5678 to 0x0005 occurs, no readdatavalid; a later read returns 0x1234_5678.
